// File: rtl/hssl_rx_link_monitor.sv
// hssl_rx_link_monitor
// Receive-side link monitor sitting behind the GT in the rx_usrclk2 domain.
// Each 32-bit rx word is classified as idle (K28.5 in byte 0), data or
// error. A run of SYNC_CNT clean idles brings the link up. While up, data
// words are forwarded one cycle later. Too many errors inside one window,
// a hunt timeout, or loss of the GT reset-done drops the link. The first
// two cases also pulse rx_reset_datapath_out.
//
// Optional feature macro: HSSL_RX_MON_ERR_CNT_EN
//   When defined, the block adds err_cnt_out, a saturating count of error
//   words seen while the link is up. Only reset_in clears it.
//
// Output handshake: vld_out qualifies dat_out for exactly one cycle per
// forwarded word. There is no ready/backpressure, so the consumer must
// accept every cycle in which vld_out is high. dat_out holds its last
// value while vld_out is low.
//
// state_dbg mirrors the FSM state: 0 RESET_WAIT, 1 HUNT, 2 UP, 3 LOST.

module hssl_rx_link_monitor #(
    parameter int SYNC_CNT     = 64,
    parameter int HUNT_TIMEOUT = 65536,
    parameter int ERR_WIN      = 1024,
    parameter int ERR_THR      = 8,
    parameter int RST_PULSE    = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] rx_data_in,
    input  logic [3:0]  rx_charisk_in,
    input  logic [3:0]  rx_disperr_in,
    input  logic [3:0]  rx_encerr_in,
    input  logic        rx_reset_done_in,
    output logic        rx_reset_datapath_out,
    output logic        link_up_out,
    output logic [31:0] dat_out,
    output logic        vld_out,
`ifdef HSSL_RX_MON_ERR_CNT_EN
    output logic [15:0] err_cnt_out,
`endif
    output logic [1:0]  state_dbg
);

    // Counter widths. Each counter only has to hold its terminal value,
    // and every width is kept at least one bit.
    localparam int SYNC_W  = (SYNC_CNT     > 1) ? $clog2(SYNC_CNT)     : 1;
    localparam int TO_W    = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;
    localparam int WIN_W   = (ERR_WIN      > 1) ? $clog2(ERR_WIN)      : 1;
    localparam int PULSE_W = (RST_PULSE    > 1) ? $clog2(RST_PULSE)    : 1;
    localparam int ERR_W   = $clog2(ERR_THR + 1);

    localparam logic [SYNC_W-1:0]  SYNC_LAST  = SYNC_W'(SYNC_CNT - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(HUNT_TIMEOUT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(ERR_WIN - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE - 1);
    localparam logic [ERR_W-1:0]   ERR_LIMIT  = ERR_W'(ERR_THR);

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        HUNT       = 2'd1,
        UP         = 2'd2,
        LOST       = 2'd3
    } state_t;

    state_t              state;
    logic [SYNC_W-1:0]   sync_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [WIN_W-1:0]    win_cnt;
    logic [ERR_W-1:0]    err_cnt;
    logic [PULSE_W-1:0]  pulse_cnt;

    logic                byte_err;
    logic                is_idle;
    logic                is_data;
    logic                is_err;
    logic                win_wrap;
    logic [ERR_W-1:0]    err_base;
    logic [ERR_W-1:0]    err_next;
    logic                err_hit;

    assign state_dbg = state;

    // Classify the current rx word. Anything that is neither a clean idle
    // nor a clean data word counts as an error.
    always_comb begin
        byte_err = (|rx_disperr_in) | (|rx_encerr_in);
        is_idle  = !byte_err && (rx_charisk_in == 4'b0001) &&
                   (rx_data_in[7:0] == 8'hBC);
        is_data  = !byte_err && (rx_charisk_in == 4'b0000);
        is_err   = !is_idle && !is_data;
    end

    // Error count for the next cycle. On the wrap cycle a new window
    // starts, so an error in that cycle is the first of the new window.
    always_comb begin
        win_wrap = (win_cnt == WIN_LAST);
        err_base = win_wrap ? '0 : err_cnt;
        err_next = err_base + ERR_W'(is_err);
        err_hit  = (err_next == ERR_LIMIT);
    end

    // Link FSM with its counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state                 <= RESET_WAIT;
            sync_cnt              <= '0;
            to_cnt                <= '0;
            win_cnt               <= '0;
            err_cnt               <= '0;
            pulse_cnt             <= '0;
            rx_reset_datapath_out <= 1'b0;
            link_up_out           <= 1'b0;
            dat_out               <= '0;
            vld_out               <= 1'b0;
        end else begin
            case (state)
                RESET_WAIT: begin
                    link_up_out           <= 1'b0;
                    vld_out               <= 1'b0;
                    rx_reset_datapath_out <= 1'b0;
                    if (rx_reset_done_in) begin
                        state    <= HUNT;
                        sync_cnt <= '0;
                        to_cnt   <= '0;
                    end
                end

                HUNT: begin
                    if (!rx_reset_done_in) begin
                        // Losing the GT reset-done wins over the timeout.
                        state <= RESET_WAIT;
                    end else if (to_cnt == TO_LAST) begin
                        state                 <= LOST;
                        pulse_cnt             <= '0;
                        rx_reset_datapath_out <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (is_idle) begin
                            if (sync_cnt == SYNC_LAST) begin
                                // The word that completes sync is not forwarded.
                                state       <= UP;
                                link_up_out <= 1'b1;
                                sync_cnt    <= '0;
                                win_cnt     <= '0;
                                err_cnt     <= '0;
                            end else begin
                                sync_cnt <= sync_cnt + 1'b1;
                            end
                        end else begin
                            sync_cnt <= '0;
                        end
                    end
                end

                UP: begin
                    if (!rx_reset_done_in) begin
                        // Drop quietly: the GT is already resetting itself.
                        state       <= RESET_WAIT;
                        link_up_out <= 1'b0;
                        vld_out     <= 1'b0;
                    end else if (err_hit) begin
                        state                 <= LOST;
                        link_up_out           <= 1'b0;
                        vld_out               <= 1'b0;
                        pulse_cnt             <= '0;
                        rx_reset_datapath_out <= 1'b1;
                    end else begin
                        win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
                        err_cnt <= err_next;
                        if (is_data) begin
                            dat_out <= rx_data_in;
                            vld_out <= 1'b1;
                        end else begin
                            vld_out <= 1'b0;
                        end
                    end
                end

                LOST: begin
                    // rx_reset_done_in is ignored until the pulse completes.
                    link_up_out <= 1'b0;
                    vld_out     <= 1'b0;
                    if (pulse_cnt == PULSE_LAST) begin
                        rx_reset_datapath_out <= 1'b0;
                        state                 <= RESET_WAIT;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= RESET_WAIT;
                end
            endcase
        end
    end

`ifdef HSSL_RX_MON_ERR_CNT_EN
    // Saturating lifetime count of error words seen while the link is up.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            err_cnt_out <= '0;
        end else if ((state == UP) && is_err && (err_cnt_out != 16'hFFFF)) begin
            err_cnt_out <= err_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hssl_rx_link_monitor.sv
// Directed testbench for hssl_rx_link_monitor.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled
// at the same point, after the DUT has updated.
// Define HSSL_RX_MON_ERR_CNT_EN to also check err_cnt_out.

module tb_hssl_rx_link_monitor;

    localparam int SYNC_CNT     = 64;
    localparam int HUNT_TIMEOUT = 65536;
    localparam int ERR_WIN      = 1024;
    localparam int ERR_THR      = 8;
    localparam int RST_PULSE    = 16;

    localparam int K_IDLE = 0;
    localparam int K_DATA = 1;
    localparam int K_ERR  = 2;

    logic        clk_in;
    logic        reset_in;
    logic [31:0] rx_data_in;
    logic [3:0]  rx_charisk_in;
    logic [3:0]  rx_disperr_in;
    logic [3:0]  rx_encerr_in;
    logic        rx_reset_done_in;
    logic        rx_reset_datapath_out;
    logic        link_up_out;
    logic [31:0] dat_out;
    logic        vld_out;
    logic [1:0]  state_dbg;
`ifdef HSSL_RX_MON_ERR_CNT_EN
    logic [15:0] err_cnt_out;
`endif

    int          n_checks;
    int          n_fail;
    int          err_variant;
    logic        link_seen;
    logic        rst_seen;
    logic [31:0] exp_q[$];
    logic [31:0] data_tbl [3];

    hssl_rx_link_monitor #(
        .SYNC_CNT     (SYNC_CNT),
        .HUNT_TIMEOUT (HUNT_TIMEOUT),
        .ERR_WIN      (ERR_WIN),
        .ERR_THR      (ERR_THR),
        .RST_PULSE    (RST_PULSE)
    ) dut (
        .clk_in                (clk_in),
        .reset_in              (reset_in),
        .rx_data_in            (rx_data_in),
        .rx_charisk_in         (rx_charisk_in),
        .rx_disperr_in         (rx_disperr_in),
        .rx_encerr_in          (rx_encerr_in),
        .rx_reset_done_in      (rx_reset_done_in),
        .rx_reset_datapath_out (rx_reset_datapath_out),
        .link_up_out           (link_up_out),
        .dat_out               (dat_out),
        .vld_out               (vld_out),
`ifdef HSSL_RX_MON_ERR_CNT_EN
        .err_cnt_out           (err_cnt_out),
`endif
        .state_dbg             (state_dbg)
    );

    // Clock generation.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one rx word of the given kind. Error words rotate through the
    // four ways a word can be malformed.
    task automatic drive(input int kind, input logic [31:0] data);
        rx_disperr_in = 4'b0000;
        rx_encerr_in  = 4'b0000;
        case (kind)
            K_IDLE: begin
                rx_data_in    = {data[31:8], 8'hBC};
                rx_charisk_in = 4'b0001;
            end
            K_DATA: begin
                rx_data_in    = data;
                rx_charisk_in = 4'b0000;
            end
            default: begin
                rx_data_in    = data;
                rx_charisk_in = 4'b0000;
                case (err_variant % 4)
                    0: rx_disperr_in = 4'b0100;
                    1: rx_encerr_in  = 4'b0001;
                    2: begin
                        rx_data_in    = {data[31:8], 8'hBC};
                        rx_charisk_in = 4'b0011;
                    end
                    default: begin
                        rx_data_in    = {data[31:8], 8'h3C};
                        rx_charisk_in = 4'b0001;
                    end
                endcase
                err_variant++;
            end
        endcase
    endtask

    // Present one word for one clock, then score any forwarded word
    // against the expected queue.
    task automatic send(input int kind, input logic [31:0] data);
        logic [31:0] exp_word;
        drive(kind, data);
        tick();
        if (link_up_out) link_seen = 1'b1;
        if (rx_reset_datapath_out) rst_seen = 1'b1;
        if (vld_out) begin
            if (exp_q.size() == 0) begin
                check_eq("vld_unexpected", {31'd0, vld_out}, 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                check_eq("fwd_data", dat_out, exp_word);
            end
        end
    endtask

    task automatic send_n(input int kind, input int n);
        for (int i = 0; i < n; i++) send(kind, 32'h1234_5600 + i);
    endtask

    // From RESET_WAIT: one data word moves the FSM into HUNT.
    task automatic enter_hunt(input string tag);
        rx_reset_done_in = 1'b1;
        send(K_DATA, 32'h0BAD_0000);
        check_eq(tag, {30'd0, state_dbg}, 32'd1);
    endtask

    // From HUNT with an empty sync run: 63 idles stay down, the 64th brings the link up.
    task automatic bring_up(input string tag);
        send_n(K_IDLE, SYNC_CNT - 1);
        check_eq({tag, "_not_yet"}, {31'd0, link_up_out}, 32'd0);
        send(K_IDLE, 32'hCAFE_0000);
        check_eq({tag, "_up"}, {31'd0, link_up_out}, 32'd1);
        check_eq({tag, "_sync_word_not_fwd"}, {31'd0, vld_out}, 32'd0);
    endtask

    // Count how many cycles the datapath reset stays high. The caller has
    // already seen it asserted.
    task automatic measure_pulse(output int len);
        len = 0;
        link_seen = 1'b0;
        while (rx_reset_datapath_out && len < 64) begin
            len++;
            send(K_IDLE, 32'h0);
        end
    endtask

    int n;
    int plen;

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        err_variant      = 0;
        link_seen        = 1'b0;
        rst_seen         = 1'b0;
        data_tbl[0]      = 32'h0123_4567;
        data_tbl[1]      = 32'hA5A5_5A5A;
        data_tbl[2]      = 32'hFFFF_0000;
        reset_in         = 1'b1;
        rx_reset_done_in = 1'b0;
        drive(K_IDLE, 32'h0);

        // Reset state.
        tick();
        tick();
        check_eq("rst_link_up", {31'd0, link_up_out}, 32'd0);
        check_eq("rst_vld", {31'd0, vld_out}, 32'd0);
        check_eq("rst_dat", dat_out, 32'd0);
        check_eq("rst_dp_reset", {31'd0, rx_reset_datapath_out}, 32'd0);
        check_eq("rst_state", {30'd0, state_dbg}, 32'd0);
`ifdef HSSL_RX_MON_ERR_CNT_EN
        check_eq("rst_err_cnt", {16'd0, err_cnt_out}, 32'd0);
`endif
        reset_in = 1'b0;
        send_n(K_IDLE, 3);
        check_eq("wait_no_done", {30'd0, state_dbg}, 32'd0);

        // T1: a broken idle run does not sync; 64 clean idles do.
        enter_hunt("t1_hunt");
        link_seen = 1'b0;
        send_n(K_IDLE, SYNC_CNT - 1);
        send(K_DATA, 32'h5555_AAAA);
        send_n(K_IDLE, SYNC_CNT - 1);
        check_eq("t1_broken_run", {31'd0, link_seen}, 32'd0);
        send(K_IDLE, 32'h0);
        check_eq("t1_up_after_64", {31'd0, link_up_out}, 32'd1);
        check_eq("t1_state_up", {30'd0, state_dbg}, 32'd2);

        // T2: forwarding with one-cycle latency. UP cycle index starts at 0.
        exp_q.push_back(32'hDEAD_BEEF);
        send(K_DATA, 32'hDEAD_BEEF);                 // idx 0
        check_eq("t2_dat", dat_out, 32'hDEAD_BEEF);
        check_eq("t2_vld", {31'd0, vld_out}, 32'd1);
        send(K_IDLE, 32'h0);                         // idx 1
        check_eq("t2_vld_low", {31'd0, vld_out}, 32'd0);
        check_eq("t2_dat_hold", dat_out, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin            // idx 2..4
            exp_q.push_back(data_tbl[i]);
            send(K_DATA, data_tbl[i]);
            check_eq("t2_burst_vld", {31'd0, vld_out}, 32'd1);
        end
        check_eq("t2_queue_drained", exp_q.size(), 32'd0);

        // T3: error window. Idles up to idx 1018, then errors at 1019..1030.
        send_n(K_IDLE, 1019 - 5);
        send_n(K_ERR, 4);                            // idx 1019..1022, window 0 holds 4
        check_eq("t3_4_before_wrap", {31'd0, link_up_out}, 32'd1);
        send_n(K_ERR, 4);                            // idx 1023 (wrap) ..1026, new window holds 4
        check_eq("t3_4_after_wrap", {31'd0, link_up_out}, 32'd1);
        send_n(K_ERR, 3);                            // idx 1027..1029, new window holds 7
        check_eq("t3_7_err_up", {31'd0, link_up_out}, 32'd1);
        check_eq("t3_err_not_fwd", {31'd0, vld_out}, 32'd0);
        send(K_ERR, 32'h0);                          // idx 1030, 8th error
        check_eq("t3_8th_drop", {31'd0, link_up_out}, 32'd0);
        check_eq("t3_pulse_start", {31'd0, rx_reset_datapath_out}, 32'd1);
        check_eq("t3_state_lost", {30'd0, state_dbg}, 32'd3);
        check_eq("t3_vld_low", {31'd0, vld_out}, 32'd0);
`ifdef HSSL_RX_MON_ERR_CNT_EN
        check_eq("t3_err_cnt", {16'd0, err_cnt_out}, 32'd12);
`endif
        measure_pulse(plen);
        check_eq("t3_pulse_len", plen, RST_PULSE);
        check_eq("t3_no_up_in_lost", {31'd0, link_seen}, 32'd0);
        check_eq("t3_back_to_wait", {30'd0, state_dbg}, 32'd0);
        enter_hunt("t3_hunt_again");

        // T5: reset-done loss drops the link without a pulse.
        bring_up("t5a");
        rx_reset_done_in = 1'b0;
        rst_seen = 1'b0;
        send(K_IDLE, 32'h0);
        check_eq("t5_drop", {31'd0, link_up_out}, 32'd0);
        check_eq("t5_state_wait", {30'd0, state_dbg}, 32'd0);
        send_n(K_IDLE, 20);
        check_eq("t5_no_pulse", {31'd0, rst_seen}, 32'd0);

        // T5 cont: reset-done loss in the same cycle as the 8th error.
        enter_hunt("t5b_hunt");
        bring_up("t5b");
        send_n(K_ERR, ERR_THR - 1);
        check_eq("t5b_7_err_up", {31'd0, link_up_out}, 32'd1);
        rx_reset_done_in = 1'b0;
        rst_seen = 1'b0;
        send(K_ERR, 32'h0);
        check_eq("t5b_drop", {31'd0, link_up_out}, 32'd0);
        check_eq("t5b_state_wait", {30'd0, state_dbg}, 32'd0);
        send_n(K_IDLE, 20);
        check_eq("t5b_no_pulse", {31'd0, rst_seen}, 32'd0);

        // T6: reset_in in cycle 5 of the LOST pulse.
        enter_hunt("t6_hunt");
        bring_up("t6");
        send_n(K_ERR, ERR_THR);
        check_eq("t6_lost", {30'd0, state_dbg}, 32'd3);
        send_n(K_IDLE, 4);
        check_eq("t6_pulse_cycle5", {31'd0, rx_reset_datapath_out}, 32'd1);
`ifdef HSSL_RX_MON_ERR_CNT_EN
        check_eq("t6_err_cnt_pre", {16'd0, err_cnt_out}, 32'd28);
`endif
        reset_in = 1'b1;
        send(K_IDLE, 32'h0);
        reset_in = 1'b0;
        check_eq("t6_dp_reset", {31'd0, rx_reset_datapath_out}, 32'd0);
        check_eq("t6_link", {31'd0, link_up_out}, 32'd0);
        check_eq("t6_vld", {31'd0, vld_out}, 32'd0);
        check_eq("t6_dat", dat_out, 32'd0);
        check_eq("t6_state", {30'd0, state_dbg}, 32'd0);
`ifdef HSSL_RX_MON_ERR_CNT_EN
        check_eq("t6_err_cnt_clr", {16'd0, err_cnt_out}, 32'd0);
`endif

        // T6 cont: three errors while up, then a link drop.
        enter_hunt("t6b_hunt");
        bring_up("t6b");
        send_n(K_ERR, 3);
        check_eq("t6b_still_up", {31'd0, link_up_out}, 32'd1);
`ifdef HSSL_RX_MON_ERR_CNT_EN
        check_eq("t6b_err_cnt", {16'd0, err_cnt_out}, 32'd3);
`endif
        rx_reset_done_in = 1'b0;
        send(K_IDLE, 32'h0);
        check_eq("t6b_drop", {31'd0, link_up_out}, 32'd0);
`ifdef HSSL_RX_MON_ERR_CNT_EN
        check_eq("t6b_err_cnt_hold", {16'd0, err_cnt_out}, 32'd3);
`endif

        // T4: HUNT with only data words runs into the timeout.
        enter_hunt("t4_hunt");
        link_seen = 1'b0;
        n = 0;
        while (!rx_reset_datapath_out && n < HUNT_TIMEOUT + 100) begin
            send(K_DATA, 32'h7000_0000 + n);
            n++;
        end
        check_eq("t4_timeout_cycles", n, HUNT_TIMEOUT);
        check_eq("t4_no_link", {31'd0, link_seen}, 32'd0);
        check_eq("t4_state_lost", {30'd0, state_dbg}, 32'd3);
        measure_pulse(plen);
        check_eq("t4_pulse_len", plen, RST_PULSE);
        check_eq("t4_back_to_wait", {30'd0, state_dbg}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
